button_conditioner: RTL

Input-side front end of the button/LED virtual interface. Synchronises a raw, asynchronous button line into the `CLK` domain, debounces it, and emits single-cycle press and release pulses, plus a stable level. The `press_pulse` output drives the `source_signal` input of downstream pulse-delay stages that feed the LEDs.

---
 rtl/button_pkg.sv | 21 ++
 rtl/sync_ff.sv | 28 ++
 rtl/button_conditioner.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types for the button conditioner: FSM state encoding, counter width
// and a saturating increment helper.
package button_pkg;

  localparam int unsigned BTN_CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  typedef logic [BTN_CNT_W-1:0] btn_cnt_t;

  // Counters stick at all-ones rather than wrapping back to zero.
  function automatic btn_cnt_t btn_sat_inc(input btn_cnt_t v);
    return (v == '1) ? v : v + btn_cnt_t'(1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous line, async active-low
// reset clears every stage to 0.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  if (STAGES < 2) begin : g_chk_stages
    $error("sync_ff: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Button front end: synchronise, debounce, emit press/release pulses and a
// stable level. Auto-repeat pulses are built only with BUTTON_CONDITIONER_REPEAT_EN.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned DEBOUNCE_CLKS      = 5,
  parameter int unsigned REPEAT_DELAY_CLKS  = 20,
  parameter int unsigned REPEAT_PERIOD_CLKS = 8
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic button_raw,
  output logic button_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("button_conditioner: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CLKS < 1) begin : g_chk_deb
    $error("button_conditioner: DEBOUNCE_CLKS must be at least 1");
  end

  localparam btn_cnt_t DEB_CNT = btn_cnt_t'(DEBOUNCE_CLKS);

  logic b_s;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (CLK),
    .rst_ni(RST_N),
    .d_i   (button_raw),
    .q_o   (b_s)
  );

  btn_state_t state_q, state_d;
  btn_cnt_t   cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic       release_q, release_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Any opposite sample in a WAIT state abandons the pending change.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (b_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = btn_cnt_t'(1);
        end
      end
      PRESS_WAIT: begin
        if (!b_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_CNT) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = btn_sat_inc(cnt_q);
        end
      end
      HELD: begin
        if (!b_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = btn_cnt_t'(1);
        end
      end
      RELEASE_WAIT: begin
        if (b_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_CNT) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = btn_sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign button_level  = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  if (REPEAT_DELAY_CLKS < 1) begin : g_chk_rdly
    $error("button_conditioner: REPEAT_DELAY_CLKS must be at least 1");
  end
  if (REPEAT_PERIOD_CLKS < 1) begin : g_chk_rper
    $error("button_conditioner: REPEAT_PERIOD_CLKS must be at least 1");
  end

  localparam btn_cnt_t RDLY_CNT = btn_cnt_t'(REPEAT_DELAY_CLKS);
  localparam btn_cnt_t RPER_CNT = btn_cnt_t'(REPEAT_PERIOD_CLKS);

  btn_cnt_t rep_q, rep_d;
  btn_cnt_t rep_target;
  logic     rep_first_q, rep_first_d;
  logic     repeat_q, repeat_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rep_q       <= '0;
      rep_first_q <= 1'b1;
      repeat_q    <= 1'b0;
    end else begin
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
      repeat_q    <= repeat_d;
    end
  end

  // Counts HELD cycles up to the current reload, freezes in RELEASE_WAIT.
  always_comb begin
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
    repeat_d    = 1'b0;
    rep_target  = rep_first_q ? RDLY_CNT : RPER_CNT;
    case (state_q)
      HELD: begin
        if (btn_sat_inc(rep_q) >= rep_target) begin
          repeat_d    = 1'b1;
          rep_d       = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_d = btn_sat_inc(rep_q);
        end
      end
      RELEASE_WAIT: begin
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
      end
      default: begin
        rep_d       = '0;
        rep_first_d = 1'b1;
      end
    endcase
  end

  assign repeat_pulse = repeat_q;
`else
  // Repeat parameters have no effect in this build.
  if (REPEAT_DELAY_CLKS == 0 && REPEAT_PERIOD_CLKS == 0) begin : g_rep_unused
  end

  assign repeat_pulse = 1'b0;
`endif

endmodule
